crc32_stream: RTL and testbench

//  Parametrised Ethernet CRC-32 engine for the MAC datapath: DW-bit beats, SOF/EOF framing, byte enables on
//  the last beat. Produces the FCS for TX and checks FCS residue on RX. Result held via valid/ready handshake.

---
 rtl/crc32_pkg.sv | 48 ++++
 rtl/crc32_stream_if.sv | 38 +++
 rtl/crc32_lanes.sv | 37 +++
 rtl/crc32_stream.sv | 214 +++++++++++++++++++++
 tb/tb_crc32_stream.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/crc32_pkg.sv
// ---------------------------------------------------------------------------
// crc32_pkg
// Shared constants, FSM state type and CRC helper functions for the
// crc32_stream Ethernet CRC-32 engine.
//   CRC32_POLY_REFL : reflected form of polynomial 0x04C11DB7
//   CRC32_INIT      : register value loaded at start of frame
//   CRC32_RESIDUE   : good-frame residue, MSB-first (conventional) orientation
//   crc_state_e     : IDLE / RUN / HOLD
//   crc32_byte()    : one reflected byte step (LSB of the byte first)
//   bitrev32()      : 32-bit bit reversal
// ---------------------------------------------------------------------------
package crc32_pkg;

  localparam logic [31:0] CRC32_POLY_REFL = 32'hEDB88320;
  localparam logic [31:0] CRC32_INIT      = 32'hFFFFFFFF;
  localparam logic [31:0] CRC32_RESIDUE   = 32'hC704DD7B;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_HOLD = 2'b10
  } crc_state_e;

  // One byte through the reflected CRC: fold the byte into the low bits,
  // then shift right eight times, xoring the polynomial when a 1 drops out.
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc,
                                             input logic [7:0]  data);
    logic [31:0] c;
    c = crc ^ {24'h000000, data};
    for (int b = 0; b < 8; b++) begin
      if (c[0]) begin
        c = (c >> 1) ^ CRC32_POLY_REFL;
      end else begin
        c = c >> 1;
      end
    end
    return c;
  endfunction

  function automatic logic [31:0] bitrev32(input logic [31:0] v);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) begin
      r[i] = v[31-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/crc32_stream_if.sv
// ---------------------------------------------------------------------------
// crc32_stream_if
// Beat-input and result-output handshake bundle of crc32_stream.
//   in_valid/in_ready, in_sof, in_eof, in_data[DW], in_be[DW/8] : beat stream
//   res_valid/res_ready, res_fcs[32], res_ok, res_bytes[CNTW],
//   res_abort                                                  : result
// master : the producer of beats / consumer of results
// slave  : the CRC engine
// ---------------------------------------------------------------------------
interface crc32_stream_if #(
  parameter int DW   = 8,
  parameter int CNTW = 16
);
  localparam int NB = DW / 8;

  logic            in_valid;
  logic            in_ready;
  logic            in_sof;
  logic            in_eof;
  logic [DW-1:0]   in_data;
  logic [NB-1:0]   in_be;
  logic            res_valid;
  logic            res_ready;
  logic [31:0]     res_fcs;
  logic            res_ok;
  logic [CNTW-1:0] res_bytes;
  logic            res_abort;

  modport master (
    output in_valid, in_sof, in_eof, in_data, in_be, res_ready,
    input  in_ready, res_valid, res_fcs, res_ok, res_bytes, res_abort
  );

  modport slave (
    input  in_valid, in_sof, in_eof, in_data, in_be, res_ready,
    output in_ready, res_valid, res_fcs, res_ok, res_bytes, res_abort
  );
endinterface

// File: rtl/crc32_lanes.sv
// ---------------------------------------------------------------------------
// crc32_lanes
// Combinational multi-lane CRC step: applies the reflected byte step to
// lanes 0..nlanes-1 of data (lane 0 = data[7:0] = earliest byte).
//   crc_in  [32]        : register before the beat
//   data    [DW]        : beat data
//   nlanes  [clog2(NB+1)] : number of valid lanes starting at lane 0
//   crc_out [32]        : register after the beat
// ---------------------------------------------------------------------------
module crc32_lanes
  import crc32_pkg::*;
#(
  parameter int DW = 8,
  localparam int NB = DW / 8,
  localparam int LW = $clog2(NB + 1)
) (
  input  logic [31:0]   crc_in,
  input  logic [DW-1:0] data,
  input  logic [LW-1:0] nlanes,
  output logic [31:0]   crc_out
);

  // Unrolled chain of byte steps; lanes at or above nlanes pass through.
  always_comb begin
    logic [31:0] c;
    c = crc_in;
    for (int i = 0; i < NB; i++) begin
      if (LW'(i) < nlanes) begin
        c = crc32_byte(c, data[8*i +: 8]);
      end else begin
        c = c;
      end
    end
    crc_out = c;
  end

endmodule

// File: rtl/crc32_stream.sv
// ---------------------------------------------------------------------------
// crc32_stream
// Ethernet CRC-32 engine with SOF/EOF framing and a held result.
//   clk, reset_n (async, active low)
//   bus : crc32_stream_if.slave (beat stream in, result out)
// Optional feature macro CRC_ERRCNT_EN adds:
//   err_cnt[15:0] out : saturating count of results with res_ok == 0
//   err_clr       in  : one-cycle clear, wins over a same-cycle increment
// The CRC register is kept in reflected orientation, so the FCS is simply
// its complement and the residue compare uses the bit-reversed register.
// ---------------------------------------------------------------------------
module crc32_stream
  import crc32_pkg::*;
#(
  parameter int          DW      = 8,
  parameter logic [31:0] INIT    = CRC32_INIT,
  parameter logic [31:0] RESIDUE = CRC32_RESIDUE,
  parameter int          CNTW    = 16
) (
  input  logic          clk,
  input  logic          reset_n,
  crc32_stream_if.slave bus
`ifdef CRC_ERRCNT_EN
  ,
  output logic [15:0]   err_cnt,
  input  logic          err_clr
`endif
);
  localparam int NB = DW / 8;
  localparam int LW = $clog2(NB + 1);

  crc_state_e      state_q, state_d;
  logic [31:0]     crc_q, crc_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic            abort_q, abort_d;
  logic            in_ready_q, res_valid_q;
  logic [31:0]     res_fcs_q, res_fcs_d;
  logic            res_ok_q, res_ok_d;
  logic [CNTW-1:0] res_bytes_q, res_bytes_d;
  logic            res_abort_q, res_abort_d;

  logic            accept_s;
  logic            capture_s;
  logic [LW-1:0]   lanes_s;
  logic [31:0]     crc_base_s, crc_next_s;
  logic [CNTW-1:0] cnt_base_s, cnt_sum_s;
  logic [CNTW:0]   cnt_wide_s;

  // Lanes used on the EOF beat: run of ones in be starting at lane 0.
  function automatic logic [LW-1:0] eof_lanes(input logic [NB-1:0] be);
    logic [LW-1:0] n;
    logic          run;
    n   = '0;
    run = 1'b1;
    for (int i = 0; i < NB; i++) begin
      if (run && be[i]) begin
        n = n + LW'(1);
      end else begin
        run = 1'b0;
      end
    end
    return n;
  endfunction

  assign accept_s = bus.in_valid & in_ready_q;

  // Beat lane count, seed selection and saturating byte count.
  always_comb begin
    if (NB == 1) begin
      lanes_s = LW'(1);
    end else if (bus.in_eof) begin
      lanes_s = eof_lanes(bus.in_be);
    end else begin
      lanes_s = LW'(NB);
    end
    crc_base_s = bus.in_sof ? INIT : crc_q;
    cnt_base_s = bus.in_sof ? {CNTW{1'b0}} : cnt_q;
    cnt_wide_s = {1'b0, cnt_base_s} + (CNTW+1)'(lanes_s);
    cnt_sum_s  = cnt_wide_s[CNTW] ? {CNTW{1'b1}} : cnt_wide_s[CNTW-1:0];
  end

  crc32_lanes #(.DW(DW)) u_lanes (
    .crc_in  (crc_base_s),
    .data    (bus.in_data),
    .nlanes  (lanes_s),
    .crc_out (crc_next_s)
  );

  // Frame FSM, CRC/count update and result capture on entry to HOLD.
  always_comb begin
    state_d     = state_q;
    crc_d       = crc_q;
    cnt_d       = cnt_q;
    abort_d     = abort_q;
    capture_s   = 1'b0;
    res_fcs_d   = res_fcs_q;
    res_ok_d    = res_ok_q;
    res_bytes_d = res_bytes_q;
    res_abort_d = res_abort_q;
    case (state_q)
      ST_IDLE: begin
        // Beats without SOF are dropped while idle.
        if (accept_s && bus.in_sof) begin
          crc_d     = crc_next_s;
          cnt_d     = cnt_sum_s;
          capture_s = bus.in_eof;
          state_d   = bus.in_eof ? ST_HOLD : ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (accept_s) begin
          crc_d     = crc_next_s;
          cnt_d     = cnt_sum_s;
          abort_d   = abort_q | bus.in_sof;
          capture_s = bus.in_eof;
          state_d   = bus.in_eof ? ST_HOLD : ST_RUN;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_HOLD: begin
        if (bus.res_ready) begin
          state_d = ST_IDLE;
          abort_d = 1'b0;
          crc_d   = INIT;
          cnt_d   = {CNTW{1'b0}};
        end else begin
          state_d = ST_HOLD;
        end
      end
      default: begin
        state_d = ST_IDLE;
        abort_d = 1'b0;
        crc_d   = INIT;
        cnt_d   = {CNTW{1'b0}};
      end
    endcase
    if (capture_s) begin
      res_fcs_d   = ~crc_next_s;
      res_ok_d    = (bitrev32(crc_next_s) == RESIDUE);
      res_bytes_d = cnt_sum_s;
      res_abort_d = abort_d;
    end else begin
      res_fcs_d   = res_fcs_q;
      res_ok_d    = res_ok_q;
      res_bytes_d = res_bytes_q;
      res_abort_d = res_abort_q;
    end
  end

  // State, datapath and result registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      crc_q       <= INIT;
      cnt_q       <= {CNTW{1'b0}};
      abort_q     <= 1'b0;
      in_ready_q  <= 1'b1;
      res_valid_q <= 1'b0;
      res_fcs_q   <= 32'h00000000;
      res_ok_q    <= 1'b0;
      res_bytes_q <= {CNTW{1'b0}};
      res_abort_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      crc_q       <= crc_d;
      cnt_q       <= cnt_d;
      abort_q     <= abort_d;
      in_ready_q  <= (state_d != ST_HOLD);
      res_valid_q <= (state_d == ST_HOLD);
      res_fcs_q   <= res_fcs_d;
      res_ok_q    <= res_ok_d;
      res_bytes_q <= res_bytes_d;
      res_abort_q <= res_abort_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.res_valid = res_valid_q;
  assign bus.res_fcs   = res_fcs_q;
  assign bus.res_ok    = res_ok_q;
  assign bus.res_bytes = res_bytes_q;
  assign bus.res_abort = res_abort_q;

`ifdef CRC_ERRCNT_EN
  logic [15:0] err_cnt_q, err_cnt_d;

  // Count results that failed the residue check as they are consumed.
  always_comb begin
    if (err_clr) begin
      err_cnt_d = 16'h0000;
    end else if ((state_q == ST_HOLD) && bus.res_ready && !res_ok_q &&
                 (err_cnt_q != 16'hFFFF)) begin
      err_cnt_d = err_cnt_q + 16'h0001;
    end else begin
      err_cnt_d = err_cnt_q;
    end
  end

  // Error counter register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_cnt_q <= 16'h0000;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_crc32_stream.sv
// ---------------------------------------------------------------------------
// tb_crc32_stream
// Directed bench for crc32_stream: one DW=8 and one DW=32 instance, fed
// known CRC-32 vectors ("123456789" -> CBF43926) and framing corner cases.
// ---------------------------------------------------------------------------
module tb_crc32_stream;
  logic clk;
  logic reset_n;
  int   n_checks;
  int   n_errors;

  crc32_stream_if #(.DW(8),  .CNTW(16)) if8  ();
  crc32_stream_if #(.DW(32), .CNTW(16)) if32 ();

`ifdef CRC_ERRCNT_EN
  logic [15:0] err_cnt8, err_cnt32;
  logic        err_clr8, err_clr32;
`endif

  crc32_stream #(.DW(8), .CNTW(16)) u_dut8 (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (if8.slave)
`ifdef CRC_ERRCNT_EN
    ,
    .err_cnt (err_cnt8),
    .err_clr (err_clr8)
`endif
  );

  crc32_stream #(.DW(32), .CNTW(16)) u_dut32 (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (if32.slave)
`ifdef CRC_ERRCNT_EN
    ,
    .err_cnt (err_cnt32),
    .err_clr (err_clr32)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic b8(input logic sof, input logic eof, input logic [7:0] d);
    @(negedge clk);
    if8.in_valid = 1'b1; if8.in_sof = sof; if8.in_eof = eof; if8.in_data = d;
    @(posedge clk); #1;
    if8.in_valid = 1'b0; if8.in_sof = 1'b0; if8.in_eof = 1'b0;
  endtask

  task automatic b32(input logic sof, input logic eof, input logic [31:0] d, input logic [3:0] be);
    @(negedge clk);
    if32.in_valid = 1'b1; if32.in_sof = sof; if32.in_eof = eof;
    if32.in_data = d; if32.in_be = be;
    @(posedge clk); #1;
    if32.in_valid = 1'b0; if32.in_sof = 1'b0; if32.in_eof = 1'b0;
  endtask

  task automatic frame8_check_str();
    logic [7:0] msg [9];
    msg = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    for (int i = 0; i < 9; i++) begin
      b8((i == 0), (i == 8), msg[i]);
    end
  endtask

  task automatic frame32_check_str();
    b32(1'b1, 1'b0, 32'h34333231, 4'hF);
    b32(1'b0, 1'b0, 32'h38373635, 4'hF);
    b32(1'b0, 1'b1, 32'h00000039, 4'b0001);
  endtask

  task automatic r8(input string tag, input logic [31:0] fcs, input logic [15:0] nb,
                    input logic ok, input logic abt);
    int n;
    n = 0;
    while (!if8.res_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_valid"}, 32'(if8.res_valid), 32'd1);
    chk({tag, "_fcs"},   if8.res_fcs, fcs);
    chk({tag, "_bytes"}, 32'(if8.res_bytes), 32'(nb));
    chk({tag, "_ok"},    32'(if8.res_ok), 32'(ok));
    chk({tag, "_abort"}, 32'(if8.res_abort), 32'(abt));
    @(negedge clk); if8.res_ready = 1'b1;
    @(posedge clk); #1; if8.res_ready = 1'b0;
  endtask

  task automatic r32(input string tag, input logic chk_fcs, input logic [31:0] fcs,
                     input logic [15:0] nb, input logic ok, input logic abt);
    int n;
    n = 0;
    while (!if32.res_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_valid"}, 32'(if32.res_valid), 32'd1);
    if (chk_fcs) begin
      chk({tag, "_fcs"}, if32.res_fcs, fcs);
    end else begin
      n = 0;
    end
    chk({tag, "_bytes"}, 32'(if32.res_bytes), 32'(nb));
    chk({tag, "_ok"},    32'(if32.res_ok), 32'(ok));
    chk({tag, "_abort"}, 32'(if32.res_abort), 32'(abt));
    @(negedge clk); if32.res_ready = 1'b1;
    @(posedge clk); #1; if32.res_ready = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    reset_n = 1'b0;
    if8.in_valid = 1'b0; if8.in_sof = 1'b0; if8.in_eof = 1'b0;
    if8.in_data = 8'h00; if8.in_be = 1'b1; if8.res_ready = 1'b0;
    if32.in_valid = 1'b0; if32.in_sof = 1'b0; if32.in_eof = 1'b0;
    if32.in_data = 32'h0; if32.in_be = 4'hF; if32.res_ready = 1'b0;
`ifdef CRC_ERRCNT_EN
    err_clr8 = 1'b0; err_clr32 = 1'b0;
`endif
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // Reset state
    chk("rst_in_ready",  32'(if8.in_ready), 32'd1);
    chk("rst_res_valid", 32'(if8.res_valid), 32'd0);
    chk("rst_fcs",       if8.res_fcs, 32'h0);
    chk("rst_ok",        32'(if8.res_ok), 32'd0);
    chk("rst_bytes",     32'(if8.res_bytes), 32'd0);
    chk("rst_abort",     32'(if8.res_abort), 32'd0);
    chk("rst32_ready",   32'(if32.in_ready), 32'd1);
    chk("rst32_valid",   32'(if32.res_valid), 32'd0);
`ifdef CRC_ERRCNT_EN
    chk("rst_errcnt",    32'(err_cnt32), 32'd0);
`endif

    // Beat without SOF while idle is dropped
    b8(1'b0, 1'b1, 8'h31);
    repeat (2) @(negedge clk);
    chk("idle_drop_valid", 32'(if8.res_valid), 32'd0);

    // DW=8 check string
    frame8_check_str();
    r8("tx8", 32'hCBF43926, 16'd9, 1'b0, 1'b0);

    // DW=32 check string, three beats
    frame32_check_str();
    r32("tx32", 1'b1, 32'hCBF43926, 16'd9, 1'b0, 1'b0);

    // Middle be ignored; EOF lanes stop at the first zero enable
    b32(1'b1, 1'b0, 32'h34333231, 4'hF);
    b32(1'b0, 1'b0, 32'h38373635, 4'h0);
    b32(1'b0, 1'b1, 32'hAABB0039, 4'b1101);
    r32("be_run", 1'b1, 32'hCBF43926, 16'd9, 1'b0, 1'b0);

    // RX good frame: data + FCS bytes 26 39 F4 CB
    b32(1'b1, 1'b0, 32'h34333231, 4'hF);
    b32(1'b0, 1'b0, 32'h38373635, 4'hF);
    b32(1'b0, 1'b0, 32'hF4392639, 4'hF);
    b32(1'b0, 1'b1, 32'h000000CB, 4'b0001);
    r32("rx_good", 1'b1, 32'h2144DF1C, 16'd13, 1'b1, 1'b0);

`ifdef CRC_ERRCNT_EN
    @(negedge clk); err_clr32 = 1'b1;
    @(posedge clk); #1; err_clr32 = 1'b0;
    chk("errcnt_clr", 32'(err_cnt32), 32'd0);
`endif

    // RX frame with one flipped data bit
    b32(1'b1, 1'b0, 32'h34333230, 4'hF);
    b32(1'b0, 1'b0, 32'h38373635, 4'hF);
    b32(1'b0, 1'b0, 32'hF4392639, 4'hF);
    b32(1'b0, 1'b1, 32'h000000CB, 4'b0001);
    r32("rx_bad", 1'b0, 32'h0, 16'd13, 1'b0, 1'b0);
`ifdef CRC_ERRCNT_EN
    chk("errcnt_one", 32'(err_cnt32), 32'd1);
`endif

    // Result held while res_ready stays low; offered beats are refused
    frame8_check_str();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if8.in_valid = 1'b1; if8.in_sof = 1'b1; if8.in_eof = 1'b1; if8.in_data = 8'h55;
      chk("hold_in_ready", 32'(if8.in_ready), 32'd0);
      chk("hold_valid",    32'(if8.res_valid), 32'd1);
      chk("hold_fcs",      if8.res_fcs, 32'hCBF43926);
      chk("hold_bytes",    32'(if8.res_bytes), 32'd9);
    end
    @(negedge clk); if8.res_ready = 1'b1;
    @(posedge clk); #1;
    if8.res_ready = 1'b0; if8.in_valid = 1'b0; if8.in_sof = 1'b0; if8.in_eof = 1'b0;
    chk("release_ready", 32'(if8.in_ready), 32'd1);
    chk("release_valid", 32'(if8.res_valid), 32'd0);
    repeat (3) @(negedge clk);
    chk("refused_beats", 32'(if8.res_valid), 32'd0);

    // SOF while running restarts and flags abort; next frame is clean
    b8(1'b1, 1'b0, 8'hAA);
    b8(1'b0, 1'b0, 8'hBB);
    frame8_check_str();
    r8("abort", 32'hCBF43926, 16'd9, 1'b0, 1'b1);
    frame8_check_str();
    r8("after_abort", 32'hCBF43926, 16'd9, 1'b0, 1'b0);

    // Async reset mid-frame discards the partial frame
    b32(1'b1, 1'b0, 32'h11223344, 4'hF);
    b32(1'b0, 1'b0, 32'h55667788, 4'hF);
    @(negedge clk); reset_n = 1'b0;
    #1;
    chk("midrst_ready", 32'(if32.in_ready), 32'd1);
    chk("midrst_valid", 32'(if32.res_valid), 32'd0);
    chk("midrst_fcs",   if32.res_fcs, 32'h0);
    @(negedge clk); reset_n = 1'b1;
    frame32_check_str();
    r32("post_rst", 1'b1, 32'hCBF43926, 16'd9, 1'b0, 1'b0);

    // Single-beat frame with no enabled lanes
    b32(1'b1, 1'b1, 32'hDEADBEEF, 4'b0000);
    r32("empty", 1'b1, 32'h00000000, 16'd0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
